// File: rtl/bf2_sdf_stage.sv
// ---------------------------------------------------------------------------
// bf2_sdf_stage
//
// Purpose:
//   One radix-2^2 single-path delay-feedback (SDF) butterfly stage.
//   Each stage owns its feedback delay line and its own sample counter.
//   Chain BF2I / BF2II / BF2I ... instances to build an R2^2SDF FFT pipeline.
//   The stage only advances on accepted samples (i_valid high), so the
//   upstream stage can stall it freely.
//
// Parameters:
//   WIDTH - signed width of each real/imag component
//   DEPTH - feedback delay length L (power of two, >= 1)
//   MODE  - 0 = BF2I, 1 = BF2II (applies -j to the last quarter of a 4L frame)
//   SCALE - 1 = butterfly outputs halved (arithmetic shift, truncate)
//           0 = butterfly outputs wrap at WIDTH bits
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   i_valid  - input sample strobe
//   i_rX     - input real component
//   i_iX     - input imag component
//   o_valid  - output sample strobe (low until the delay line is primed)
//   o_rZ     - output real component (holds while idle)
//   o_iZ     - output imag component (holds while idle)
//   o_frame  - marks the first butterfly-sum output of each frame
// ---------------------------------------------------------------------------
module bf2_sdf_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int MODE  = 0,
    parameter int SCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_rX,
    input  logic [WIDTH-1:0] i_iX,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_rZ,
    output logic [WIDTH-1:0] o_iZ,
    output logic             o_frame
);

    localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 0;
    localparam int CW = LW + 1 + ((MODE != 0) ? 1 : 0);

    logic [CW-1:0]    cnt;
    logic [LW+1:0]    cntExt;
    logic             phaseS;
    logic             phaseT;
    logic             primed;
    logic             lastFill;
    logic             frameHit;

    logic [WIDTH-1:0] delayR [DEPTH];
    logic [WIDTH-1:0] delayI [DEPTH];
    logic [WIDTH-1:0] dR;
    logic [WIDTH-1:0] dI;

    logic [WIDTH-1:0] xR;
    logic [WIDTH-1:0] xI;
    logic [WIDTH:0]   sumR;
    logic [WIDTH:0]   sumI;
    logic [WIDTH:0]   diffR;
    logic [WIDTH:0]   diffI;
    logic [WIDTH-1:0] outR;
    logic [WIDTH-1:0] outI;
    logic [WIDTH-1:0] feedR;
    logic [WIDTH-1:0] feedI;

    // The counter is widened by one zero bit in BF2I so the twiddle-phase bit
    // can be read uniformly; in BF2I it is always zero.
    assign cntExt   = (LW + 2)'(cnt);
    assign phaseS   = cnt[LW];
    assign phaseT   = cntExt[LW+1];
    assign lastFill = (cnt == CW'(DEPTH - 1));
    assign frameHit = (cnt == CW'(DEPTH));

    assign dR = delayR[DEPTH-1];
    assign dI = delayI[DEPTH-1];

    // Keep the top WIDTH bits when halving, otherwise the low WIDTH bits
    // (which silently wraps on overflow).
    function automatic logic [WIDTH-1:0] narrow(input logic [WIDTH:0] v);
        return (SCALE != 0) ? v[WIDTH:1] : v[WIDTH-1:0];
    endfunction

    // Trivial -j twiddle for BF2II: swap components and negate the new imag.
    // Negating the most negative value wraps back onto itself.
    always_comb begin
        xR = i_rX;
        xI = i_iX;
        if ((MODE != 0) && phaseS && phaseT) begin
            xR = i_iX;
            xI = -i_rX;
        end
    end

    // Butterfly at WIDTH+1 bits so the carry is available for scaling.
    always_comb begin
        sumR  = {dR[WIDTH-1], dR} + {xR[WIDTH-1], xR};
        sumI  = {dI[WIDTH-1], dI} + {xI[WIDTH-1], xI};
        diffR = {dR[WIDTH-1], dR} - {xR[WIDTH-1], xR};
        diffI = {dI[WIDTH-1], dI} - {xI[WIDTH-1], xI};
    end

    // Fill phase passes the oldest delayed sample out and stores the new one;
    // butterfly phase emits the sum and recirculates the difference.
    always_comb begin
        outR  = dR;
        outI  = dI;
        feedR = xR;
        feedI = xI;
        if (phaseS) begin
            outR  = narrow(sumR);
            outI  = narrow(sumI);
            feedR = narrow(diffR);
            feedI = narrow(diffI);
        end
    end

    // Sequencing, output register and delay line. Everything except o_valid
    // and o_frame freezes while i_valid is low. primed is first set on the
    // L-th accepted sample, so the first L outputs are flagged invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            primed  <= 1'b0;
            o_valid <= 1'b0;
            o_frame <= 1'b0;
            o_rZ    <= '0;
            o_iZ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                delayR[i] <= '0;
                delayI[i] <= '0;
            end
        end else begin
            o_valid <= i_valid && primed;
            o_frame <= i_valid && primed && frameHit;
            if (i_valid) begin
                cnt  <= cnt + CW'(1);
                o_rZ <= outR;
                o_iZ <= outI;
                if (lastFill) begin
                    primed <= 1'b1;
                end
                for (int i = DEPTH - 1; i > 0; i--) begin
                    delayR[i] <= delayR[i-1];
                    delayI[i] <= delayI[i-1];
                end
                delayR[0] <= feedR;
                delayI[0] <= feedI;
            end
        end
    end

endmodule

// File: tb/tb_bf2_sdf_stage.sv
// ---------------------------------------------------------------------------
// tb_bf2_sdf_stage
//
// Purpose:
//   Directed self-checking bench for bf2_sdf_stage. Four instances share the
//   clock, reset and input bus, each built with a different parameter set:
//     u0 : L=2, BF2I,  no scaling
//     u1 : L=2, BF2I,  halved outputs
//     u2 : L=1, BF2II, no scaling
//     u3 : L=1, BF2I,  no scaling (wrap-around cases)
//   Each test task resets everything and checks only its own instance.
// ---------------------------------------------------------------------------
module tb_bf2_sdf_stage;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        iValid = 1'b0;
    logic [15:0] iR = '0;
    logic [15:0] iI = '0;

    logic        v0, v1, v2, v3;
    logic        f0, f1, f2, f3;
    logic [15:0] r0, r1, r2, r3;
    logic [15:0] q0, q1, q2, q3;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    bf2_sdf_stage #(.WIDTH(16), .DEPTH(2), .MODE(0), .SCALE(0)) u0 (
        .clk(clk), .rst_n(rstN), .i_valid(iValid), .i_rX(iR), .i_iX(iI),
        .o_valid(v0), .o_rZ(r0), .o_iZ(q0), .o_frame(f0));

    bf2_sdf_stage #(.WIDTH(16), .DEPTH(2), .MODE(0), .SCALE(1)) u1 (
        .clk(clk), .rst_n(rstN), .i_valid(iValid), .i_rX(iR), .i_iX(iI),
        .o_valid(v1), .o_rZ(r1), .o_iZ(q1), .o_frame(f1));

    bf2_sdf_stage #(.WIDTH(16), .DEPTH(1), .MODE(1), .SCALE(0)) u2 (
        .clk(clk), .rst_n(rstN), .i_valid(iValid), .i_rX(iR), .i_iX(iI),
        .o_valid(v2), .o_rZ(r2), .o_iZ(q2), .o_frame(f2));

    bf2_sdf_stage #(.WIDTH(16), .DEPTH(1), .MODE(0), .SCALE(0)) u3 (
        .clk(clk), .rst_n(rstN), .i_valid(iValid), .i_rX(iR), .i_iX(iI),
        .o_valid(v3), .o_rZ(r3), .o_iZ(q3), .o_frame(f3));

    // Drive one cycle on the falling edge, then sample just after the rising edge.
    task automatic stepSample(input int re, input int im, input logic v);
        @(negedge clk);
        iValid = v;
        iR     = 16'(re);
        iI     = 16'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN   = 1'b0;
        iValid = 1'b0;
        iR     = '0;
        iI     = '0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] allR [4];
        logic [15:0] allI [4];
        logic        allV [4];
        logic        allF [4];
        @(negedge clk);
        rstN   = 1'b0;
        iValid = 1'b1;
        iR     = 16'd7;
        iI     = 16'd9;
        @(posedge clk);
        #1;
        allR = '{r0, r1, r2, r3};
        allI = '{q0, q1, q2, q3};
        allV = '{v0, v1, v2, v3};
        allF = '{f0, f1, f2, f3};
        for (int u = 0; u < 4; u++) begin
            nChecks++;
            if (allV[u] !== 1'b0 || allF[u] !== 1'b0 || allR[u] !== 16'd0 || allI[u] !== 16'd0) begin
                nFails++;
                $display("[TB] FAIL reset_u%0d: got v=%b f=%b re=%0d im=%0d expected all 0",
                         u, allV[u], allF[u], allR[u], allI[u]);
            end
        end
        @(negedge clk);
        iValid = 1'b0;
        rstN   = 1'b1;
    endtask

    // L=2 BF2I, no scaling. gap = idle cycles after each sample.
    task automatic test_mode0_scale0(input bit withReset, input int gap, input string tag);
        int   inR  [8] = '{1, 2, 3, 4, 5, 6, 0, 0};
        int   expR [6] = '{4, 6, -2, -2, 5, 6};
        logic expF [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int   holdR = 0;
        logic ev;
        if (withReset) doReset();
        for (int k = 0; k < 8; k++) begin
            stepSample(inR[k], 0, 1'b1);
            ev = (k >= 2);
            nChecks++;
            if (v0 !== ev) begin
                nFails++;
                $display("[TB] FAIL %s_valid[%0d]: got %b expected %b", tag, k, v0, ev);
            end
            if (ev) begin
                holdR = expR[k-2];
                nChecks++;
                if (r0 !== 16'(expR[k-2]) || q0 !== 16'd0 || f0 !== expF[k-2]) begin
                    nFails++;
                    $display("[TB] FAIL %s_out[%0d]: got re=%0d im=%0d frame=%b expected re=%0d im=0 frame=%b",
                             tag, k - 2, $signed(r0), $signed(q0), f0, expR[k-2], expF[k-2]);
                end
            end
            for (int g = 0; g < gap; g++) begin
                stepSample(99, 99, 1'b0);
                nChecks++;
                if (v0 !== 1'b0 || f0 !== 1'b0 || r0 !== 16'(holdR)) begin
                    nFails++;
                    $display("[TB] FAIL %s_idle[%0d]: got v=%b f=%b re=%0d expected v=0 f=0 re=%0d",
                             tag, k, v0, f0, $signed(r0), holdR);
                end
            end
        end
    endtask

    task automatic test_mode0_scale1();
        int   inR  [8] = '{1, 2, 3, 4, 5, 6, 0, 0};
        int   expR [6] = '{2, 3, -1, -1, 2, 3};
        doReset();
        for (int k = 0; k < 8; k++) begin
            stepSample(inR[k], 0, 1'b1);
            nChecks++;
            if (v1 !== (k >= 2)) begin
                nFails++;
                $display("[TB] FAIL scale1_valid[%0d]: got %b expected %b", k, v1, (k >= 2));
            end
            if (k >= 2) begin
                nChecks++;
                if (r1 !== 16'(expR[k-2]) || q1 !== 16'd0) begin
                    nFails++;
                    $display("[TB] FAIL scale1_out[%0d]: got re=%0d im=%0d expected re=%0d im=0",
                             k - 2, $signed(r1), $signed(q1), expR[k-2]);
                end
            end
        end
    endtask

    task automatic test_mode1();
        int   inR  [6] = '{1, 2, 3, 4, 0, 0};
        int   expR [5] = '{3, -1, 3, 3, 0};
        int   expI [5] = '{0, 0, -4, 4, 0};
        logic expF [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        doReset();
        for (int k = 0; k < 6; k++) begin
            stepSample(inR[k], 0, 1'b1);
            nChecks++;
            if (v2 !== (k >= 1)) begin
                nFails++;
                $display("[TB] FAIL mode1_valid[%0d]: got %b expected %b", k, v2, (k >= 1));
            end
            if (k >= 1) begin
                nChecks++;
                if (r2 !== 16'(expR[k-1]) || q2 !== 16'(expI[k-1]) || f2 !== expF[k-1]) begin
                    nFails++;
                    $display("[TB] FAIL mode1_out[%0d]: got re=%0d im=%0d frame=%b expected re=%0d im=%0d frame=%b",
                             k - 1, $signed(r2), $signed(q2), f2, expR[k-1], expI[k-1], expF[k-1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int   inR  [5] = '{32767, 1, -32768, 1, 0};
        int   expR [4] = '{-32768, 32766, -32767, 32767};
        logic expF [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        doReset();
        for (int k = 0; k < 5; k++) begin
            stepSample(inR[k], 0, 1'b1);
            nChecks++;
            if (v3 !== (k >= 1)) begin
                nFails++;
                $display("[TB] FAIL wrap_valid[%0d]: got %b expected %b", k, v3, (k >= 1));
            end
            if (k >= 1) begin
                nChecks++;
                if (r3 !== 16'(expR[k-1]) || q3 !== 16'd0 || f3 !== expF[k-1]) begin
                    nFails++;
                    $display("[TB] FAIL wrap_out[%0d]: got re=%0d im=%0d frame=%b expected re=%0d im=0 frame=%b",
                             k - 1, $signed(r3), $signed(q3), f3, expR[k-1], expF[k-1]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        test_mode0_scale0(1'b1, 3, "gaps");
    endtask

    // Reset after three samples must discard them; the rerun then matches a clean start.
    task automatic test_mid_reset();
        doReset();
        stepSample(1, 0, 1'b1);
        stepSample(2, 0, 1'b1);
        stepSample(3, 0, 1'b1);
        @(negedge clk);
        rstN   = 1'b0;
        iValid = 1'b0;
        @(posedge clk);
        #1;
        nChecks++;
        if (v0 !== 1'b0 || f0 !== 1'b0 || r0 !== 16'd0 || q0 !== 16'd0) begin
            nFails++;
            $display("[TB] FAIL midreset_clear: got v=%b f=%b re=%0d im=%0d expected all 0",
                     v0, f0, $signed(r0), $signed(q0));
        end
        @(negedge clk);
        rstN = 1'b1;
        test_mode0_scale0(1'b0, 0, "midreset");
    endtask

    initial begin
        test_reset();
        test_mode0_scale0(1'b1, 0, "t1");
        test_mode0_scale1();
        test_mode1();
        test_gaps();
        test_mid_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
